// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field
// positions and the handler vector used by the pipeline.
package cp0_pkg;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] code;
    } cause_t;

    // Return address for a take: a delay-slot victim restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] adj;
        adj = bd ? pc - 32'd4 : pc;
        return {adj[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline <-> CP0 bus: mtc0/mfc0 access, M-stage victim info and take request.
interface cp0_int_ctrl_if;
    logic [5:0]  hwint;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] victim_pc;
    logic        victim_bd;
    logic [4:0]  exc_code;
    logic        eret;
    logic        req;
    logic [31:0] epc;

    modport master (
        output hwint, we, addr, wdata, victim_pc, victim_bd, exc_code, eret,
        input  rdata, req, epc
    );
    modport slave (
        input  hwint, we, addr, wdata, victim_pc, victim_bd, exc_code, eret,
        output rdata, req, epc
    );
endinterface

// File: rtl/cp0_pend_eval.sv
// Combinational pending evaluation: masked interrupt, exception, next ExcCode.
module cp0_pend_eval
    import cp0_pkg::*;
(
    input  logic [5:0] hwint,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code,
    output logic       int_pend,
    output logic       exc_pend,
    output logic [4:0] next_code
);
    assign int_pend  = (|(hwint & im)) & ie & ~exl;
    assign exc_pend  = (exc_code != EXC_INT) & ~exl;
    // Interrupt outranks a coincident exception.
    assign next_code = int_pend ? EXC_INT : exc_code;
endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 SR/Cause/EPC/PRId with same-cycle take request beside the M stage.
// Optional macro CP0_BD_EN: store Cause.BD and back EPC up for delay-slot victims.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h2020_0707
) (
    input  logic clk,
    input  logic reset,
    cp0_int_ctrl_if.slave bus
);
    sr_t         sr;
    cause_t      cause;
    logic [31:0] epc_r;
    logic        int_pend, exc_pend, req, bd_in;
    logic [4:0]  next_code;
    logic [31:0] rdata;

`ifdef CP0_BD_EN
    assign bd_in = bus.victim_bd;
`else
    assign bd_in = 1'b0;
`endif

    cp0_pend_eval u_pend (
        .hwint     (bus.hwint),
        .im        (sr.im),
        .ie        (sr.ie),
        .exl       (sr.exl),
        .exc_code  (bus.exc_code),
        .int_pend  (int_pend),
        .exc_pend  (exc_pend),
        .next_code (next_code)
    );

    assign req = int_pend | exc_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            cause <= '0;
            epc_r <= '0;
        end else begin
            cause.ip <= bus.hwint;
            // A take flushes the writer, so eret/mtc0 only act when no take.
            if (req) begin
                sr.exl     <= 1'b1;
                cause.code <= next_code;
                cause.bd   <= bd_in;
                epc_r      <= epc_of(bus.victim_pc, bd_in);
            end else if (bus.eret) begin
                sr.exl <= 1'b0;
            end else if (bus.we) begin
                case (bus.addr)
                    REG_SR:  sr <= '{im:  bus.wdata[SR_IM_LO +: 6],
                                     exl: bus.wdata[SR_EXL],
                                     ie:  bus.wdata[SR_IE]};
                    REG_EPC: epc_r <= {bus.wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.addr)
            REG_SR: begin
                rdata[SR_IM_LO +: 6] = sr.im;
                rdata[SR_EXL]        = sr.exl;
                rdata[SR_IE]         = sr.ie;
            end
            REG_CAUSE: begin
                rdata[CAUSE_BD]            = cause.bd;
                rdata[CAUSE_IP_LO +: 6]    = cause.ip;
                rdata[CAUSE_EXC_LO +: 5]   = cause.code;
            end
            REG_EPC:  rdata = epc_r;
            REG_PRID: rdata = PRID;
            default:  ;
        endcase
    end

    assign bus.rdata = rdata;
    assign bus.req   = req;
    assign bus.epc   = epc_r;
endmodule
